// File: rtl/cam_capture_stream.sv
// cam_capture_stream: OV7670-class parallel camera capture into a tagged valid/ready pixel stream.
// Optional build macro CAM_CAPTURE_DECIMATE_EN adds a decimate input (keep even x / even y only).
module cam_capture_stream #(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned BYTES_PER_PIX = 2,
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter int unsigned XCLK_DIV      = 1,
   parameter int unsigned MAX_W         = 640,
   parameter int unsigned MAX_H         = 480
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            enable,
`ifdef CAM_CAPTURE_DECIMATE_EN
   input  logic                            decimate,
`endif
   input  logic                            cam_pclk,
   input  logic                            cam_vsync,
   input  logic                            cam_href,
   input  logic [DATA_W-1:0]               cam_data,
   output logic                            cam_xclk,
   output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
   output logic [$clog2(MAX_W)-1:0]        pix_x,
   output logic [$clog2(MAX_H)-1:0]        pix_y,
   output logic                            pix_sof,
   output logic                            pix_eol,
   output logic                            pix_valid,
   input  logic                            pix_ready,
   output logic [15:0]                     frame_count,
   output logic                            overflow,
   input  logic                            overflow_clr
);

   localparam int unsigned PIX_W = DATA_W * BYTES_PER_PIX;
   localparam int unsigned X_W   = $clog2(MAX_W);
   localparam int unsigned Y_W   = $clog2(MAX_H);
   localparam int unsigned XC_W  = $clog2(MAX_W + 1);
   localparam int unsigned YC_W  = $clog2(MAX_H + 1);
   localparam int unsigned BI_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam int unsigned DIV_W = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned ENT_W = PIX_W + X_W + Y_W + 2;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;

   // Sensor master clock, free-running from reset
   logic [DIV_W-1:0] div_q;
   logic             xclk_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q  <= '0;
         xclk_q <= 1'b0;
      end else if (div_q == DIV_W'(XCLK_DIV - 1)) begin
         div_q  <= '0;
         xclk_q <= ~xclk_q;
      end else begin
         div_q  <= div_q + DIV_W'(1);
      end
   end

   assign cam_xclk = xclk_q;

   // Input synchronisers; pclk carries one extra stage for edge detection
   logic [2:0]        pclk_s_q;
   logic [1:0]        vsync_s_q, href_s_q;
   logic [DATA_W-1:0] data_s1_q, data_s2_q;
   logic              vsync_p_q, href_p_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pclk_s_q  <= '0;
         vsync_s_q <= '0;
         href_s_q  <= '0;
         data_s1_q <= '0;
         data_s2_q <= '0;
         vsync_p_q <= 1'b0;
         href_p_q  <= 1'b0;
      end else begin
         pclk_s_q  <= {pclk_s_q[1:0], cam_pclk};
         vsync_s_q <= {vsync_s_q[0], cam_vsync};
         href_s_q  <= {href_s_q[0], cam_href};
         data_s1_q <= cam_data;
         data_s2_q <= data_s1_q;
         vsync_p_q <= vsync_s_q[1];
         href_p_q  <= href_s_q[1];
      end
   end

   logic pclk_rise_c, vsync_rise_c, vsync_fall_c, href_fall_c;
   assign pclk_rise_c  = pclk_s_q[1] & ~pclk_s_q[2];
   assign vsync_rise_c = vsync_s_q[1] & ~vsync_p_q;
   assign vsync_fall_c = ~vsync_s_q[1] & vsync_p_q;
   assign href_fall_c  = ~href_s_q[1] & href_p_q;

   logic [1:0]       state_q, state_d;
   logic [XC_W-1:0]  x_q, x_d;
   logic [YC_W-1:0]  y_q, y_d;
   logic [BI_W-1:0]  bidx_q, bidx_d;
   logic [PIX_W-1:0] acc_q, acc_d;
   logic             line_pix_q, line_pix_d;
   logic             sof_pend_q, sof_pend_d;
   logic             hold_vld_q, hold_vld_d;
   logic [ENT_W-1:0] hold_ent_q, hold_ent_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic             push_c, keep_c;
   logic [ENT_W-1:0] push_ent_c;
   logic [X_W-1:0]   new_x_c;
   logic [Y_W-1:0]   new_y_c;
`ifdef CAM_CAPTURE_DECIMATE_EN
   logic             decim_q, decim_d;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         bidx_q      <= '0;
         acc_q       <= '0;
         line_pix_q  <= 1'b0;
         sof_pend_q  <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_ent_q  <= '0;
         frame_cnt_q <= '0;
`ifdef CAM_CAPTURE_DECIMATE_EN
         decim_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         bidx_q      <= bidx_d;
         acc_q       <= acc_d;
         line_pix_q  <= line_pix_d;
         sof_pend_q  <= sof_pend_d;
         hold_vld_q  <= hold_vld_d;
         hold_ent_q  <= hold_ent_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef CAM_CAPTURE_DECIMATE_EN
         decim_q     <= decim_d;
`endif
      end
   end

   // Frame FSM and pixel assembly; one held pixel lets eol be known when it is pushed
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      bidx_d      = bidx_q;
      acc_d       = acc_q;
      line_pix_d  = line_pix_q;
      sof_pend_d  = sof_pend_q;
      hold_vld_d  = hold_vld_q;
      hold_ent_d  = hold_ent_q;
      frame_cnt_d = frame_cnt_q;
      push_c      = 1'b0;
      push_ent_c  = hold_ent_q;
      keep_c      = (x_q < XC_W'(MAX_W)) && (y_q < YC_W'(MAX_H));
      new_x_c     = X_W'(x_q);
      new_y_c     = Y_W'(y_q);
`ifdef CAM_CAPTURE_DECIMATE_EN
      decim_d     = decim_q;
      if (decim_q) begin
         keep_c  = keep_c && !x_q[0] && !y_q[0];
         new_x_c = X_W'(x_q >> 1);
         new_y_c = Y_W'(y_q >> 1);
      end
`endif
      case (state_q)
         S_IDLE: begin
            if (vsync_s_q[1]) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (vsync_fall_c && enable) begin
               state_d    = S_CAPTURE;
               x_d        = '0;
               y_d        = '0;
               bidx_d     = '0;
               line_pix_d = 1'b0;
               sof_pend_d = 1'b1;
               hold_vld_d = 1'b0;
`ifdef CAM_CAPTURE_DECIMATE_EN
               decim_d    = decimate;
`endif
            end
         end
         S_CAPTURE: begin
            if (vsync_rise_c) begin
               state_d     = S_ARMED;
               frame_cnt_d = frame_cnt_q + 16'd1;
               push_c      = hold_vld_q;
               push_ent_c  = {hold_ent_q[ENT_W-1:1], 1'b1};
               hold_vld_d  = 1'b0;
            end else if (href_fall_c) begin
               push_c     = hold_vld_q;
               push_ent_c = {hold_ent_q[ENT_W-1:1], 1'b1};
               hold_vld_d = 1'b0;
               x_d        = '0;
               bidx_d     = '0;
               line_pix_d = 1'b0;
               if (line_pix_q && (y_q != YC_W'(MAX_H))) y_d = y_q + YC_W'(1);
            end else if (pclk_rise_c && href_s_q[1]) begin
               for (int b = 0; b < int'(BYTES_PER_PIX); b++) begin
                  if (bidx_q == BI_W'(b)) acc_d[(BYTES_PER_PIX-1-b)*DATA_W +: DATA_W] = data_s2_q;
               end
               if (bidx_q == BI_W'(BYTES_PER_PIX - 1)) begin
                  bidx_d     = '0;
                  line_pix_d = 1'b1;
                  if (x_q != XC_W'(MAX_W)) x_d = x_q + XC_W'(1);
                  if (keep_c) begin
                     push_c     = hold_vld_q;
                     push_ent_c = hold_ent_q;
                     hold_vld_d = 1'b1;
                     hold_ent_d = {acc_d, new_x_c, new_y_c, sof_pend_q, 1'b0};
                     sof_pend_d = 1'b0;
                  end
               end else begin
                  bidx_d = bidx_q + BI_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output FIFO with a registered head so the stream outputs come straight from flops
   logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ENT_W-1:0] out_ent_q, head_c;
   logic             valid_q, overflow_q;
   logic             pop_c, full_c, push_ok_c, drop_c;

   always_comb begin
      pop_c     = valid_q & pix_ready;
      full_c    = (cnt_q == CW'(FIFO_DEPTH));
      push_ok_c = push_c & (~full_c | pop_c);
      drop_c    = push_c & full_c & ~pop_c;
      wr_ptr_d  = push_ok_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d     = cnt_q + CW'(push_ok_c) - CW'(pop_c);
      head_c    = (push_ok_c && (rd_ptr_d == wr_ptr_q)) ? push_ent_c : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         out_ent_q  <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok_c) mem_q[wr_ptr_q] <= push_ent_c;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= (cnt_d != '0);
         if (cnt_d != '0) out_ent_q <= head_c;
         if (drop_c)            overflow_q <= 1'b1;
         else if (overflow_clr) overflow_q <= 1'b0;
      end
   end

   assign {pix_data, pix_x, pix_y, pix_sof, pix_eol} = out_ent_q;
   assign pix_valid   = valid_q;
   assign overflow    = overflow_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_stream.sv
// tb_cam_capture_stream: frame-level stimulus with a pixel scoreboard for cam_capture_stream.
// Build with CAM_CAPTURE_DECIMATE_EN defined to add the decimation frame.
module tb_cam_capture_stream;

   localparam int MAX_W = 640;
   localparam int MAX_H = 480;

   typedef struct {
      logic [15:0] d;
      int          x;
      int          y;
      bit          sof;
      bit          eol;
   } exp_t;

   typedef struct {
      int lines;
      int pix;
      int en;
      int raise_line;
      int dec;
      int ready_mode;
      int exp_pix;
      int exp_frames;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n, enable, cam_pclk, cam_vsync, cam_href, pix_ready, overflow_clr;
   logic [7:0]  cam_data;
   logic        cam_xclk, pix_sof, pix_eol, pix_valid, overflow;
   logic [15:0] pix_data, frame_count;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
`ifdef CAM_CAPTURE_DECIMATE_EN
   logic        dec_in;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   int   rx_cnt  = 0;
   int   ready_mode = 0;
   exp_t exp_q[$];

   always #10 clk = ~clk;

   cam_capture_stream dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
`ifdef CAM_CAPTURE_DECIMATE_EN
      .decimate     (dec_in),
`endif
      .cam_pclk     (cam_pclk),
      .cam_vsync    (cam_vsync),
      .cam_href     (cam_href),
      .cam_data     (cam_data),
      .cam_xclk     (cam_xclk),
      .pix_data     (pix_data),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_sof      (pix_sof),
      .pix_eol      (pix_eol),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .frame_count  (frame_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   // Sink ready: 0 = stalled, 1 = always ready, other = random
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       pix_ready = 1'b0;
         1:       pix_ready = 1'b1;
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Stream monitor: scoreboard pop on transfer, plus hold check while stalled
   exp_t        e;
   logic        prev_hold = 1'b0;
   logic [37:0] prev_bus;
   always @(negedge clk) begin
      if (reset_n && pix_valid && pix_ready) begin
         rx_cnt++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stream_extra: got d=%h x=%0d y=%0d, required no pixel", pix_data, pix_x, pix_y);
         end else begin
            e = exp_q.pop_front();
            if (pix_data !== e.d || pix_x !== 10'(e.x) || pix_y !== 9'(e.y) ||
                pix_sof !== e.sof || pix_eol !== e.eol) begin
               n_fail++;
               $display("FAIL stream_word: got d=%h x=%0d y=%0d sof=%0d eol=%0d, required d=%h x=%0d y=%0d sof=%0d eol=%0d",
                        pix_data, pix_x, pix_y, pix_sof, pix_eol, e.d, e.x, e.y, e.sof, e.eol);
            end
         end
      end
      if (reset_n && prev_hold) begin
         n_tests++;
         if ({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol} !== prev_bus) begin
            n_fail++;
            $display("FAIL stall_hold: got %h, required %h", {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol}, prev_bus);
         end
      end
      prev_hold = reset_n && pix_valid && !pix_ready;
      prev_bus  = {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol};
   end

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_data = b;
      cam_pclk = 1'b0;
      tick(2);
      cam_pclk = 1'b1;
      tick(2);
   endtask

   // Drives one frame (bytes 0xA1, 0xB2, ...) and queues the pixels the capture must emit
   task automatic drive_frame(input int lines, input int pix, input bit cap, input bit dec,
                              input int keep_max, input int raise_line, input bit do_start);
      int         kept;
      int         limit;
      int         last;
      logic [7:0] bc, b0, b1;
      exp_t       ex;
      kept = 0;
      bc   = 8'hA1;
      if (do_start) begin
         cam_vsync = 1'b1;
         tick(8);
         cam_vsync = 1'b0;
         tick(8);
      end
      for (int l = 0; l < lines; l++) begin
         if (l == raise_line) enable = 1'b1;
         limit    = (pix < MAX_W) ? pix : MAX_W;
         last     = dec ? ((limit - 1) & ~1) : limit - 1;
         cam_href = 1'b1;
         for (int p = 0; p < pix; p++) begin
            b0 = bc;
            b1 = bc + 8'h11;
            bc = bc + 8'h22;
            if (cap && p < MAX_W && l < MAX_H && (!dec || (p % 2 == 0 && l % 2 == 0))) begin
               if (kept < keep_max) begin
                  ex.d   = {b0, b1};
                  ex.x   = dec ? p / 2 : p;
                  ex.y   = dec ? l / 2 : l;
                  ex.sof = (kept == 0);
                  ex.eol = (p == last);
                  exp_q.push_back(ex);
               end
               kept++;
            end
            send_byte(b0);
            send_byte(b1);
         end
         cam_pclk = 1'b0;
         cam_href = 1'b0;
         tick(8);
      end
      cam_vsync = 1'b1;
      tick(8);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         tick(1);
         n++;
      end
      check("drain_remaining", exp_q.size(), 0);
      exp_q.delete();
      tick(8);
      check("drain_no_extra_valid", 32'(pix_valid), 0);
   endtask

   vec_t tv[$];
   int   rx0;
   logic prev_x;

   initial begin
      tv.push_back('{4,   3,   1, -1, 0, 1, 12,   1});
      tv.push_back('{2,   5,   1, -1, 0, 2, 10,   2});
      tv.push_back('{3,   3,   0,  1, 0, 1, 0,    2});
      tv.push_back('{2,   2,   1, -1, 0, 1, 4,    3});
      tv.push_back('{2,   700, 1, -1, 0, 1, 1280, 4});

      reset_n = 1'b0; enable = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
      cam_data = '0; pix_ready = 1'b0; overflow_clr = 1'b0;
`ifdef CAM_CAPTURE_DECIMATE_EN
      dec_in = 1'b0;
`endif
      tick(5);
      check("rst_valid",   32'(pix_valid),   0);
      check("rst_data",    32'(pix_data),    0);
      check("rst_xy",      {pix_x, pix_y},   0);
      check("rst_sof_eol", {pix_sof, pix_eol}, 0);
      check("rst_frames",  32'(frame_count), 0);
      check("rst_ovf",     32'(overflow),    0);
      check("rst_xclk",    32'(cam_xclk),    0);
      tick(1);
      check("rst_xclk_hold", 32'(cam_xclk), 0);

      reset_n = 1'b1;
      tick(1);
      prev_x = cam_xclk;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("xclk_toggle", 32'(cam_xclk), 32'(!prev_x));
         prev_x = cam_xclk;
      end

      foreach (tv[i]) begin
         rx0        = rx_cnt;
         enable     = 1'(tv[i].en);
         ready_mode = tv[i].ready_mode;
         drive_frame(tv[i].lines, tv[i].pix, tv[i].en != 0, tv[i].dec != 0, 1 << 30, tv[i].raise_line, 1'b1);
         wait_drain();
         check($sformatf("vec%0d_pixels", i), rx_cnt - rx0, tv[i].exp_pix);
         check($sformatf("vec%0d_frames", i), 32'(frame_count), tv[i].exp_frames);
      end

      // Stalled sink: 10-pixel line into an 8-entry FIFO
      ready_mode = 0;
      enable     = 1'b1;
      rx0        = rx_cnt;
      tick(4);
      drive_frame(1, 10, 1'b1, 1'b0, 8, -1, 1'b1);
      check("ovf_set",        32'(overflow),  1);
      check("ovf_full_valid", 32'(pix_valid), 1);
      ready_mode = 1;
      wait_drain();
      check("ovf_kept",   rx_cnt - rx0, 8);
      check("ovf_sticky", 32'(overflow), 1);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      tick(1);
      check("ovf_clr",    32'(overflow), 0);
      check("ovf_frames", 32'(frame_count), 5);

`ifdef CAM_CAPTURE_DECIMATE_EN
      rx0    = rx_cnt;
      dec_in = 1'b1;
      drive_frame(4, 4, 1'b1, 1'b1, 1 << 30, -1, 1'b1);
      dec_in = 1'b0;
      wait_drain();
      check("dec_pixels", rx_cnt - rx0, 4);
      check("dec_frames", 32'(frame_count), 6);
`endif

      // Reset in the middle of a line, then lines without a fresh vsync
      ready_mode = 0;
      cam_vsync  = 1'b1;
      tick(8);
      cam_vsync  = 1'b0;
      tick(8);
      cam_href   = 1'b1;
      send_byte(8'hA1);
      send_byte(8'hB2);
      send_byte(8'hC3);
      reset_n = 1'b0;
      tick(2);
      check("midrst_valid",  32'(pix_valid),   0);
      check("midrst_frames", 32'(frame_count), 0);
      check("midrst_ovf",    32'(overflow),    0);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      reset_n  = 1'b1;
      tick(4);
      ready_mode = 1;
      rx0        = rx_cnt;
      drive_frame(2, 3, 1'b0, 1'b0, 1 << 30, -1, 1'b0);
      tick(20);
      check("midrst_no_capture", rx_cnt - rx0, 0);
      check("midrst_no_frame",   32'(frame_count), 0);
      drive_frame(2, 3, 1'b1, 1'b0, 1 << 30, -1, 1'b1);
      wait_drain();
      check("resume_pixels", rx_cnt - rx0, 6);
      check("resume_frames", 32'(frame_count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cam_capture_stream.md
Name: cam_capture_stream

Overview:
- Parametrised camera capture front end for OV7670-class parallel sensors on GPIO_0.
- Generates the sensor XCLK and samples PCLK, VSYNC, HREF and DATA as data in the single system clock domain.
- Assembles multi-byte pixels, tags each with x/y and start-of-frame/end-of-line markers, and buffers them in a FIFO.
- Feeds a valid/ready stream consumed by the frame-buffer writer ahead of the VGA path.

Parameters:
- DATA_W, 8, camera data bus width.
- BYTES_PER_PIX, 2, camera bytes per pixel (RGB565 = 2); first byte lands in the MSBs.
- FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, at least 2.
- XCLK_DIV, 1, cam_xclk half-period in clk cycles.
- MAX_W, 640, pixels per line accepted.
- MAX_H, 480, lines per frame accepted.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; sampled only at frame start.
- cam_pclk  in  1  sensor pixel clock, sampled as data.
- cam_vsync  in  1  sensor vsync; high = vertical blanking.
- cam_href  in  1  sensor line valid.
- cam_data  in  DATA_W  sensor data.
- cam_xclk  out  1  sensor master clock.
- pix_data  out  DATA_W*BYTES_PER_PIX  pixel word.
- pix_x  out  clog2(MAX_W)  pixel column.
- pix_y  out  clog2(MAX_H)  pixel row.
- pix_sof  out  1  first pixel of the frame.
- pix_eol  out  1  last pixel of the line.
- pix_valid  out  1  stream valid.
- pix_ready  in  1  stream ready.
- frame_count  out  16  completed frames, wraps.
- overflow  out  1  sticky FIFO overflow flag.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, xclk divider 0.
- cam_xclk toggles every XCLK_DIV clk cycles; runs continuously out of reset, independent of enable.
- Synchroniser: 2-flop sync on pclk, vsync, href and data, plus one extra stage on pclk.
- pclk rise = sync2 & ~sync3. vsync/href and data are used from the stage aligned with that edge.
- State IDLE → ARMED on synced vsync high.
- ARMED → CAPTURE on vsync falling edge if enable = 1; clears x, y and byte index, sets sof_pending.
- ARMED stays ARMED on vsync falling edge if enable = 0.
- CAPTURE → ARMED on vsync rising edge: frame_count += 1, any held pixel flushed with eol = 1.
- CAPTURE, on a pclk rise with href = 1: store the byte at the current byte index. On the last byte, form a pixel.
- Pending-pixel register (one-pixel delay so eol is known at push time):
  - A new pixel pushes the previously held pixel with eol = 0, then is held.
  - On href falling edge, the held pixel is pushed with eol = 1; x ← 0, y += 1, byte index ← 0.
  - A line with zero pixels does not advance y.
- sof = 1 only on the first pixel pushed after entering CAPTURE.
- Pixels with x ≥ MAX_W or y ≥ MAX_H are discarded and counters saturate; no push, no overflow.
- Push to a full FIFO: pixel dropped, overflow ← 1.
- overflow_clr clears overflow. If a drop occurs in the same cycle, set wins.
- Stream: FIFO head is presented when pix_valid = 1 and transfers on valid & ready. Outputs are held stable while valid & ~ready.
- Latency: pixel visible on the stream 1 clk after it is pushed when the FIFO is empty.
- Push and pop in the same cycle on a full FIFO succeed; no overflow.
- enable deasserted mid-frame: the current frame completes; no new frame starts.
- Reset mid-frame: everything clears; capture resumes only after a new vsync high then low.

Optional Feature:
- Macro CAM_CAPTURE_DECIMATE_EN.
- Defined: adds input decimate (1 bit), sampled at frame start. When 1, only even x and even y pixels are pushed. pix_x/pix_y report decimated coordinates (x/2, y/2). eol is attached to the last kept pixel of a kept line.
- Undefined: no port, every pixel is pushed.

Test Plan:
- Reset, XCLK_DIV = 1: cam_xclk toggles every clk (25 MHz); all outputs 0 while reset_n = 0.
- Frame of 4 lines × 3 pixels, bytes 0xA1, 0xB2, ... with pix_ready = 1: 12 pixels; first word 0xA1B2 with sof = 1, x = 0, y = 0; eol = 1 at x = 2; frame_count = 1 after vsync rises.
- pix_ready = 0 with FIFO_DEPTH = 8 over a 10-pixel line: 8 entries kept, overflow = 1, entries intact in order. overflow_clr → 0.
- enable = 0 at vsync fall, raised mid-frame: no pixels that frame; the next frame captures normally.
- Line with 700 pixels, MAX_W = 640: 640 pushed, last at x = 639 with eol = 1, y advances by 1.
- CAM_CAPTURE_DECIMATE_EN defined, decimate = 1, 4 × 4 frame: 4 pixels at (0,0), (1,0), (0,1), (1,1), eol on x = 1.
